dbg_wb_arbiter: RTL and testbench
=================================

// Module: dbg_wb_arbiter
// PURPOSE
//  Shares the LM32 debug Wishbone slave (pipelined, STALL plus delayed ACK) between two requesters:
//  m0 = host Etherbone debug bridge, m1 = local UART debug bridge.
//  Round-robin grant, held for the whole bus cycle. Tracks outstanding strobes. Returns ERR on an
//  ACK timeout so a hung debug core cannot lock out either requester.
// PARAMETERS
//  ADDR_WIDTH   32   address width, all ports
//  DATA_WIDTH   32   data width; SEL width = DATA_WIDTH/8
//  MAX_OUT      2    max strobes accepted but not yet acked (>=1)
//  TIMEOUT      64   cycles with outstanding>0 and no ACK before an ERR is returned (>=ACK_DELAY+2)
// PORTS
//  clk_i           in   1    system clock
//  rst_i           in   1    synchronous reset, active high
//  mN_cyc_i        in   1    requester N (N=0,1) bus cycle
//  mN_stb_i        in   1    requester N strobe
//  mN_we_i         in   1    requester N write enable
//  mN_adr_i        in   AW   requester N address
//  mN_dat_i        in   DW   requester N write data
//  mN_sel_i        in   DW/8 requester N byte select
//  mN_ack_o        out  1    ACK forwarded to requester N
//  mN_err_o        out  1    timeout error to requester N (1-cycle pulse)
//  mN_stall_o      out  1    stall to requester N
//  mN_dat_o        out  DW   read data (s_dat_i, unregistered)
//  s_cyc_o/s_stb_o/s_we_o  out 1   to debug slave
//  s_adr_o         out  AW   to debug slave
//  s_dat_o         out  DW   to debug slave
//  s_sel_o         out  DW/8 to debug slave
//  s_ack_i         in   1    slave ACK
//  s_stall_i       in   1    slave STALL
//  s_dat_i         in   DW   slave read data
// BEHAVIOUR
//  FSM states: IDLE, GNT0, GNT1, DRAIN. Reset: IDLE, outstanding=0, timer=0, last_gnt=1 (m0 wins the
//   first tie). s_cyc_o=s_stb_o=0; all mN_ack_o/mN_err_o=0; both mN_stall_o=1.
//  IDLE: stall=1 to both. If only one requester has cyc, grant it next cycle. If both have cyc,
//   grant the one != last_gnt. Grant latency is 1 cycle; no strobe is accepted in IDLE.
//  GNTx: s_cyc_o=1. s_adr/dat/sel/we are muxed from mx. s_stb_o = mx_stb_i & ~full,
//   where full = (outstanding==MAX_OUT).
//   mx_stall_o = s_stall_i | full. The non-granted requester sees stall=1, ack=0, err=0.
//  Accept = s_stb_o & ~s_stall_i. outstanding += accept - s_ack_i. A same-cycle accept and ACK
//   leave the count unchanged. An ACK when outstanding==0 is dropped and not forwarded.
//  mx_ack_o = s_ack_i & (outstanding>0) & mx_cyc_i (combinational).
//  mx_cyc_i falls: if outstanding==0, go to IDLE and set last_gnt=x. Otherwise go to DRAIN
//   (s_cyc_o=1, s_stb_o=0, ACKs absorbed, not forwarded). Leave DRAIN when outstanding reaches 0.
//  Timer: cleared on any s_ack_i or when outstanding==0; otherwise increments in GNTx/DRAIN.
//   timer==TIMEOUT-1: in GNTx, pulse mx_err_o for 1 cycle. In all cases clear outstanding and
//   timer, drive s_cyc_o=0 for the next cycle, go to IDLE, set last_gnt=x.
//   Late ACKs after this are dropped (outstanding==0).
//  rst_i mid-transfer: FSM to IDLE within 1 cycle. Counters cleared. In-flight ACKs are dropped.
//  Arithmetic: outstanding is $clog2(MAX_OUT+1) bits, never wraps (full gating). Timer is
//   $clog2(TIMEOUT) bits, saturates by reset-to-0 on timeout.
// STRUCTURE
//  Shared package dbg_wb_pkg: state enum (IDLE/GNT0/GNT1/DRAIN). This block reuses the existing
//   TRUE/FALSE defines.
//  One natural sub-module: dbg_wb_rr_pick (2-way round-robin select from cyc pair + last_gnt).
//  Everything else stays inline: mux, outstanding counter, timer.
// TESTING
//  1. m0 only, write 0x0000_0405 to a slave with 8-cycle ACK delay: grant at +1, s_stb_o 1 cycle,
//     stall high for 7 cycles, single m0_ack_o, m1 untouched.
//  2. m0 and m1 assert cyc same cycle after reset: m0 granted first. m1 granted the cycle after
//     m0 drops cyc. Next tie grants m1 first.
//  3. MAX_OUT=2, zero-stall slave, 3 back-to-back strobes: 3rd strobe stalled until the first ACK.
//     Exactly 3 ACKs forwarded, outstanding returns to 0.
//  4. m1 drops cyc with 1 outstanding: DRAIN, the late ACK is not seen on m1_ack_o, then IDLE.
//     A pending m0 request is granted 1 cycle after outstanding reaches 0.
//  5. Slave never ACKs, TIMEOUT=64: m0_err_o pulses exactly at cycle 64 after the last ACK or
//     accept. s_cyc_o is low for 1 cycle. An ACK injected at cycle 70 is dropped.
//  6. rst_i asserted during GNT1 with 2 outstanding: next cycle IDLE, s_cyc_o=0, stalls=1. No ACKs
//     are forwarded afterwards.

Source files
------------

// File: rtl/dbg_wb_pkg.sv
// rtl/dbg_wb_pkg.sv - shared types for the debug Wishbone arbiter
package dbg_wb_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/dbg_wb_rr_pick.sv
// rtl/dbg_wb_rr_pick.sv - two-way round-robin select from a cyc pair
module dbg_wb_rr_pick (
  input  logic cyc0,
  input  logic cyc1,
  input  logic last_gnt,
  output logic req,
  output logic pick
);

  // On a tie the requester that did not hold the bus last time wins.
  assign req  = cyc0 | cyc1;
  assign pick = (cyc0 & cyc1) ? ~last_gnt : cyc1;

endmodule

// File: rtl/dbg_wb_arbiter.sv
// rtl/dbg_wb_arbiter.sv - round-robin share of the LM32 debug Wishbone slave with ACK timeout
module dbg_wb_arbiter
  import dbg_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUT    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_stall_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_stall_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_stall_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] out_next;
  logic [TW-1:0] timer;
  logic          last_gnt;
  logic          req;
  logic          pick;
  logic          granted;
  logic          sel1;
  logic          cur_cyc;
  logic          cur_stb;
  logic          full;
  logic          accept;
  logic          ack_v;
  logic          timeout;

  dbg_wb_rr_pick u_pick (
    .cyc0     (m0_cyc_i),
    .cyc1     (m1_cyc_i),
    .last_gnt (last_gnt),
    .req      (req),
    .pick     (pick)
  );

  assign granted = (state == GNT0) || (state == GNT1);
  assign sel1    = (state == GNT1);
  assign cur_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = sel1 ? m1_stb_i : m0_stb_i;
  assign full    = (outstanding == OW'(MAX_OUT));

  assign s_cyc_o = (state != IDLE);
  assign s_stb_o = granted & cur_stb & ~full;
  assign s_we_o  = sel1 ? m1_we_i  : m0_we_i;
  assign s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = sel1 ? m1_sel_i : m0_sel_i;

  // ACKs with nothing outstanding (stale, or after a timeout/reset) are never counted or forwarded.
  assign accept  = s_stb_o & ~s_stall_i;
  assign ack_v   = s_ack_i & (outstanding != '0);
  assign timeout = (state != IDLE) & ~s_ack_i & (outstanding != '0) & (timer == TW'(TIMEOUT - 1));

  assign m0_ack_o   = ack_v & (state == GNT0) & m0_cyc_i;
  assign m1_ack_o   = ack_v & (state == GNT1) & m1_cyc_i;
  assign m0_err_o   = timeout & (state == GNT0);
  assign m1_err_o   = timeout & (state == GNT1);
  assign m0_stall_o = (state == GNT0) ? (s_stall_i | full) : TRUE;
  assign m1_stall_o = (state == GNT1) ? (s_stall_i | full) : TRUE;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  always_comb begin
    out_next = outstanding;
    if (accept && !ack_v)
      out_next = outstanding + OW'(1);
    else if (!accept && ack_v)
      out_next = outstanding - OW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      outstanding <= '0;
      timer       <= '0;
      last_gnt    <= TRUE;
    end else begin
      outstanding <= timeout ? '0 : out_next;

      if (timeout || s_ack_i || (outstanding == '0))
        timer <= '0;
      else if (state != IDLE)
        timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          if (req)
            state <= pick ? GNT1 : GNT0;
        end
        GNT0, GNT1: begin
          if (timeout) begin
            state    <= IDLE;
            last_gnt <= sel1;
          end else if (!cur_cyc) begin
            state    <= (outstanding == '0) ? IDLE : DRAIN;
            last_gnt <= sel1;
          end
        end
        DRAIN: begin
          if (timeout || (out_next == '0))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_wb_arbiter.sv
// tb/tb_dbg_wb_arbiter.sv - directed vector bench for dbg_wb_arbiter
module tb_dbg_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic        m0_ack_o, m0_err_o, m0_stall_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0] m1_adr_i = 32'h200, m1_dat_i = 32'h1111;
  logic [3:0]  m1_sel_i = 4'h3;
  logic        m1_ack_o, m1_err_o, m1_stall_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i = 0, s_stall_i = 0;
  logic [31:0] s_dat_i = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  dbg_wb_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUT(2), .TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i),
    .s_dat_i(s_dat_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // in  = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
  // exp = {s_cyc, s_stb, m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[26];

  initial begin
    int err_k;
    int err_n;
    int stb_n;
    int ack_n;
    int stall_n;
    int m1_bad;

    vt[0]  = '{"reset_idle",   7'b0000000, 8'b00001001};
    vt[1]  = '{"tie_idle",     7'b0111100, 8'b00001001};
    vt[2]  = '{"gnt0_acc1",    7'b0111100, 8'b11000001};
    vt[3]  = '{"gnt0_acc2",    7'b0111100, 8'b11000001};
    vt[4]  = '{"gnt0_full",    7'b0111100, 8'b10001001};
    vt[5]  = '{"gnt0_ack1",    7'b0111110, 8'b10101001};
    vt[6]  = '{"gnt0_acc3",    7'b0111100, 8'b11000001};
    vt[7]  = '{"gnt0_ack2",    7'b0101110, 8'b10101001};
    vt[8]  = '{"gnt0_ack3",    7'b0101110, 8'b10100001};
    vt[9]  = '{"gnt0_stray",   7'b0101110, 8'b10000001};
    vt[10] = '{"m0_drop",      7'b0001100, 8'b10000001};
    vt[11] = '{"idle_m1",      7'b0001100, 8'b00001001};
    vt[12] = '{"gnt1_acc",     7'b0001100, 8'b11001000};
    vt[13] = '{"m1_drop_out1", 7'b0110000, 8'b10001000};
    vt[14] = '{"drain_wait",   7'b0110000, 8'b10001001};
    vt[15] = '{"drain_ack",    7'b0110010, 8'b10001001};
    vt[16] = '{"idle_m0",      7'b0110000, 8'b00001001};
    vt[17] = '{"gnt0_drop",    7'b0000000, 8'b10000001};
    vt[18] = '{"tie2_idle",    7'b0111100, 8'b00001001};
    vt[19] = '{"tie2_gnt1",    7'b0111100, 8'b11001000};
    vt[20] = '{"gnt1_acc2",    7'b0111100, 8'b11001000};
    vt[21] = '{"rst_mid",      7'b1111000, 8'b10001001};
    vt[22] = '{"post_rst",     7'b0001110, 8'b00001001};
    vt[23] = '{"late_ack",     7'b0001010, 8'b10001000};
    vt[24] = '{"gnt1_drop",    7'b0000000, 8'b10001000};
    vt[25] = '{"final_idle",   7'b0000000, 8'b00001001};

    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      {rst_i, m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_stall_i} = vt[i].in;
      #1;
      chk(vt[i].name,
          {24'd0, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o},
          {24'd0, vt[i].exp});
    end

    // Single m0 write against a slave that stalls while busy and ACKs 8 cycles after accept.
    stb_n = 0; ack_n = 0; stall_n = 0; m1_bad = 0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      m0_cyc_i = (k <= 9);
      m0_stb_i = (k <= 1);
      m0_we_i = 1'b1;
      m0_adr_i = 32'h0000_0100;
      m0_dat_i = 32'h0000_0405;
      m0_sel_i = 4'hf;
      s_stall_i = (k >= 2 && k <= 8);
      s_ack_i = (k == 9);
      s_dat_i = (k == 9) ? 32'hcafe_f00d : 32'h0;
      #1;
      if (s_stb_o) stb_n++;
      if (m0_ack_o) ack_n++;
      if (k >= 1 && m0_stall_o) stall_n++;
      if (m1_ack_o || m1_err_o || !m1_stall_o || m0_err_o) m1_bad++;
      if (k == 1) begin
        chk("wr_adr", s_adr_o, 32'h0000_0100);
        chk("wr_dat", s_dat_o, 32'h0000_0405);
        chk("wr_we", {31'd0, s_we_o}, 32'd1);
        chk("wr_sel", {28'd0, s_sel_o}, 32'hf);
      end
      if (k == 9) begin
        chk("rd_dat_pass", m0_dat_o, 32'hcafe_f00d);
        chk("wr_ack_at_9", {31'd0, m0_ack_o}, 32'd1);
      end
    end
    chk("wr_stb_cycles", stb_n, 1);
    chk("wr_ack_count", ack_n, 1);
    chk("wr_stall_cycles", stall_n, 7);
    chk("wr_m1_untouched", m1_bad, 0);

    // Slave never ACKs: error 64 cycles after the accept at k=1, then a stray ACK.
    err_k = -1; err_n = 0;
    for (int k = 0; k <= 75; k++) begin
      @(negedge clk_i);
      m0_cyc_i = 1'b1;
      m0_stb_i = (k <= 1);
      m0_we_i = 1'b0;
      s_stall_i = 1'b0;
      s_ack_i = (k == 71);
      s_dat_i = 32'h0;
      #1;
      if (m0_err_o) begin
        err_n++;
        if (err_k < 0) err_k = k;
      end
      if (k == 65) chk("to_cyc_before", {31'd0, s_cyc_o}, 32'd1);
      if (k == 66) chk("to_cyc_low", {31'd0, s_cyc_o}, 32'd0);
      if (k == 67) chk("to_cyc_regrant", {31'd0, s_cyc_o}, 32'd1);
      if (k == 71) chk("to_late_ack", {31'd0, m0_ack_o}, 32'd0);
    end
    chk("to_err_cycle", err_k, 65);
    chk("to_err_count", err_n, 1);

    @(negedge clk_i);
    m0_cyc_i = 1'b0;
    s_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("end_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
